// File: rtl/extremum_finder_pkg.sv
// extremum_finder_pkg
// Shared types and constants for the extremum finder: controller state
// encoding and the max/min mode selector values.
package extremum_finder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/extremum_finder_if.sv
// extremum_finder_if
// Handshake, configuration and memory-read bundle of the extremum finder.
//   start, mode, last   : scan request and its latched parameters
//   din / addr          : combinational memory read (data valid same cycle)
//   result, result_idx  : extremum value and lowest index holding it
//   match_count         : entries equal to result (0 when counting is not built)
//   busy, done          : state decodes, done pulses once per completed scan
// master modport drives requests and memory data; slave is the finder.
interface extremum_finder_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  import extremum_finder_pkg::*;

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] result_idx;
  logic [ADDR_W:0]   match_count;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, last, din,
    input  addr, result, result_idx, match_count, busy, done
  );

  modport slave (
    input  start, mode, last, din,
    output addr, result, result_idx, match_count, busy, done
  );

endinterface

// File: rtl/extremum_finder_ctrl.sv
// extremum_finder_ctrl
// Scan sequencer. Turns the start request and datapath compare flags into
// strobes for the datapath registers.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   start_i             : scan request (only honoured in IDLE)
//   addr_eq_last_i      : current address is the final one
//   din_better_i        : din beats the running result in the latched mode
//   din_equal_i         : din equals the running result
//   accept_o            : latch mode/last, clear address
//   load_o              : seed result from entry 0
//   addr_inc_o          : advance the read address
//   take_o              : replace result/index with the current entry
//   tie_o               : another entry equal to result
//   busy_o, done_o      : state decodes
//
// state | meaning
// IDLE  | waiting for start; results held
// LOAD  | seed result from address 0
// SCAN  | compare addresses 1..last
// DONE  | results final, done pulse
module extremum_finder_ctrl
  import extremum_finder_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic addr_eq_last_i,
  input  logic din_better_i,
  input  logic din_equal_i,
  output logic accept_o,
  output logic load_o,
  output logic addr_inc_o,
  output logic take_o,
  output logic tie_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0] state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_o   = 1'b0;
    load_o     = 1'b0;
    addr_inc_o = 1'b0;
    take_o     = 1'b0;
    tie_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_o = 1'b1;
        // address is 0 here, so the flag means last == 0
        if (addr_eq_last_i) begin
          state_d = ST_DONE;
        end else begin
          addr_inc_o = 1'b1;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        take_o = din_better_i;
        tie_o  = din_equal_i;
        if (addr_eq_last_i) state_d = ST_DONE;
        else                addr_inc_o = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/extremum_finder.sv
// extremum_finder
// Scans an asynchronous-read memory from address 0 to a run-time last
// address and reports the maximum (mode 0) or minimum (mode 1) value and
// the lowest index holding it. Datapath lives here; sequencing is in
// extremum_finder_ctrl.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus            : extremum_finder_if slave (start/mode/last/din in,
//                    addr/result/result_idx/match_count/busy/done out)
// Build option: EXTREMUM_FINDER_COUNT_EN builds the match counter;
// without it match_count is tied to 0.
module extremum_finder
  import extremum_finder_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input logic              clk_i,
  input logic              reset_i,
  extremum_finder_if.slave bus
);

  logic              mode_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] idx_q;

  logic addr_eq_last, din_better, din_equal;
  logic accept, load, addr_inc, take, tie;

  assign addr_eq_last = (addr_q == last_q);
  assign din_better   = (mode_q == MODE_MIN) ? (bus.din < result_q)
                                             : (bus.din > result_q);
  assign din_equal    = (bus.din == result_q);

  extremum_finder_ctrl u_ctrl (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (bus.start),
    .addr_eq_last_i (addr_eq_last),
    .din_better_i   (din_better),
    .din_equal_i    (din_equal),
    .accept_o       (accept),
    .load_o         (load),
    .addr_inc_o     (addr_inc),
    .take_o         (take),
    .tie_o          (tie),
    .busy_o         (bus.busy),
    .done_o         (bus.done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q   <= MODE_MAX;
      last_q   <= '0;
      addr_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
    end else begin
      if (accept) begin
        mode_q <= bus.mode;
        last_q <= bus.last;
        addr_q <= '0;
      end else if (addr_inc) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (load) begin
        result_q <= bus.din;
        idx_q    <= '0;
      end else if (take) begin
        result_q <= bus.din;
        idx_q    <= addr_q;
      end
    end
  end

`ifdef EXTREMUM_FINDER_COUNT_EN
  logic [ADDR_W:0] cnt_q;

  // a new extremum restarts the count at 1; equal entries add to it
  always_ff @(posedge clk_i) begin
    if (reset_i)            cnt_q <= '0;
    else if (load || take)  cnt_q <= (ADDR_W+1)'(1);
    else if (tie)           cnt_q <= cnt_q + (ADDR_W+1)'(1);
  end

  assign bus.match_count = cnt_q;
`else
  logic unused_tie;
  assign unused_tie      = tie;
  assign bus.match_count = '0;
`endif

  assign bus.addr       = addr_q;
  assign bus.result     = result_q;
  assign bus.result_idx = idx_q;

endmodule

// File: tb/tb_extremum_finder.sv
module tb_extremum_finder;
  import extremum_finder_pkg::*;

  localparam int DW = 4;
  localparam int AW = 4;
`ifdef EXTREMUM_FINDER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  extremum_finder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  extremum_finder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  logic [DW-1:0] mem [16];
  assign bus.din = mem[bus.addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem counts cycles of the current scan still to come (busy while > 0,
  // done when 1); results are computed directly from the memory at accept.
  bit m_valid = 1'b0;
  int m_rem = 0, m_last = 0, m_res = 0, m_idx = 0, m_cnt = 0, m_addr_idle = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_rem = 0; m_last = 0;
      m_res = 0; m_idx = 0; m_cnt = 0; m_addr_idle = 0;
    end else if (m_valid) begin
      if (m_rem == 0) begin
        if (bus.start === 1'b1) begin
          int best, bi, c;
          m_last = int'(bus.last);
          m_rem  = m_last + 2;
          best = int'(mem[0]); bi = 0;
          for (int i = 1; i <= m_last; i++) begin
            if ((bus.mode == MODE_MIN) ? (int'(mem[i]) < best) : (int'(mem[i]) > best)) begin
              best = int'(mem[i]); bi = i;
            end
          end
          c = 0;
          for (int i = 0; i <= m_last; i++) if (int'(mem[i]) == best) c++;
          m_res = best; m_idx = bi; m_cnt = CNT_EN ? c : 0;
          m_addr_idle = m_last;
        end
      end else begin
        m_rem--;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && !reset) begin
      int exp_addr;
      check("busy", 32'(bus.busy), 32'(m_rem != 0));
      check("done", 32'(bus.done), 32'(m_rem == 1));
      if (m_rem == 0) exp_addr = m_addr_idle;
      else exp_addr = (m_last + 2 - m_rem < m_last) ? (m_last + 2 - m_rem) : m_last;
      check("addr", 32'(bus.addr), 32'(exp_addr));
      if (m_rem <= 1) begin
        check("result", 32'(bus.result), 32'(m_res));
        check("result_idx", 32'(bus.result_idx), 32'(m_idx));
        check("match_count", 32'(bus.match_count), 32'(m_cnt));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic fill(input int v0, v1, v2, v3, v4);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = DW'(v0); mem[1] = DW'(v1); mem[2] = DW'(v2);
    mem[3] = DW'(v3); mem[4] = DW'(v4);
  endtask

  // Accepts a scan in the next cycle (cycle 0) and checks the done cycle and
  // final outputs against hand-computed literals.
  task automatic run_scan(input string tag, input bit md, input int lst, input bit hold,
                          input int exp_cyc, input int exp_res, input int exp_idx,
                          input int exp_cnt, input int exp_addr);
    int n;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = md; bus.last = AW'(lst);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    n = 1; seen = 1'b0;
    while (n <= 40 && !seen) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, " done cycle"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_cyc));
    check({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check({tag, " result_idx"}, 32'(bus.result_idx), 32'(exp_idx));
    check({tag, " match_count"}, 32'(bus.match_count), CNT_EN ? 32'(exp_cnt) : 32'd0);
    check({tag, " addr"}, 32'(bus.addr), 32'(exp_addr));
  endtask

  initial begin
    int dn, dcyc;
    reset = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.last = '0;
    fill(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset match_count", 32'(bus.match_count), 32'd0);

    fill(3, 9, 2, 9, 1);
    run_scan("max5", MODE_MAX, 4, 1'b0, 6, 9, 1, 2, 4);
    run_scan("min5", MODE_MIN, 4, 1'b0, 6, 1, 4, 1, 4);

    fill(5, 2, 8, 2, 2);
    run_scan("mintie", MODE_MIN, 4, 1'b0, 6, 2, 1, 3, 4);

    fill(7, 1, 1, 1, 1);
    run_scan("last0", MODE_MAX, 0, 1'b0, 2, 7, 0, 1, 0);

    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    run_scan("full", MODE_MAX, 15, 1'b0, 17, 15, 15, 1, 15);

    // reset in cycle 3 of a scan
    fill(3, 9, 2, 9, 1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = MODE_MAX; bus.last = AW'(4);
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("pre-reset result", 32'(bus.result), 32'd9);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst addr", 32'(bus.addr), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst result_idx", 32'(bus.result_idx), 32'd0);
    check("rst match_count", 32'(bus.match_count), 32'd0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("rst no done", 32'(dn), 32'd0);
    run_scan("after rst", MODE_MAX, 4, 1'b0, 6, 9, 1, 2, 4);

    // start held high: done pulse in cycle 4 ignores start, re-accept in cycle 5
    fill(4, 6, 5, 0, 0);
    run_scan("hold", MODE_MAX, 2, 1'b1, 4, 6, 1, 1, 2);
    @(posedge clk); #1;
    @(posedge clk); #1 bus.start = 1'b0;
    dn = 0; dcyc = -1;
    for (int c = 6; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin dn++; dcyc = c; end
      @(posedge clk); #1;
    end
    check("hold redo count", 32'(dn), 32'd1);
    check("hold redo cycle", 32'(dcyc), 32'd9);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
